cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl.sv | 102 ++++++++++
 tb/tb_cache_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// cache_ctrl: write-through, no-write-allocate cache controller between the MEM stage and a single-port SRAM.
// Ports: clk/rst (async, active-high); pipeline side mem_r_en, mem_w_en, address, wdata -> rdata, ready;
// cache side cache_addr, cache_hit, cache_rdata, cache_fill_en, cache_fill_w0/w1, cache_inval;
// SRAM side sram_addr, sram_wdata, sram_r_en, sram_w_en, sram_rdata, sram_ready.
// Define CACHE_CTRL_PERF_CNT_EN to add saturating hit_count/miss_count outputs.
module cache_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [18:0] cache_addr,
  input  logic        cache_hit,
  input  logic [31:0] cache_rdata,
  output logic        cache_fill_en,
  output logic [31:0] cache_fill_w0,
  output logic [31:0] cache_fill_w1,
  output logic        cache_inval,
  output logic [18:0] sram_addr,
  output logic [31:0] sram_wdata,
  output logic        sram_r_en,
  output logic        sram_w_en,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
`ifdef CACHE_CTRL_PERF_CNT_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);
  typedef enum logic [2:0] {IDLE, FETCH0, FETCH1, FILL, WRITE} state_t;
  state_t state;
  logic [15:0] blk;
  logic [31:0] word0, word1, rdata_q, fill_word;
  logic st, ld_hit, ld_miss, unused;
  // The cache/SRAM window starts at byte 1024; only the low 19 bits of the offset are kept.
  assign cache_addr = address[18:0] - 19'd1024;
  assign unused = ^address[31:19];
  // Stores win over loads when both enables are high.
  assign st = state == IDLE && mem_w_en;
  assign ld_hit = state == IDLE && !mem_w_en && mem_r_en && cache_hit;
  assign ld_miss = state == IDLE && !mem_w_en && mem_r_en && !cache_hit;
  assign fill_word = address[2] ? word1 : word0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      blk <= '0;
      word0 <= '0;
      word1 <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (st) state <= WRITE;
          else if (ld_miss) begin
            state <= FETCH0;
            blk <= cache_addr[18:3];
          end else if (ld_hit) rdata_q <= cache_rdata;
        end
        FETCH0: if (sram_ready) begin
          word0 <= sram_rdata;
          state <= FETCH1;
        end
        FETCH1: if (sram_ready) begin
          word1 <= sram_rdata;
          state <= FILL;
        end
        FILL: begin
          rdata_q <= fill_word;
          state <= IDLE;
        end
        WRITE: if (sram_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  // Hits and the fill cycle return data directly; otherwise the last completed load is held.
  assign rdata = ld_hit ? cache_rdata : state == FILL ? fill_word : rdata_q;
  assign ready = state == IDLE ? !mem_w_en && (!mem_r_en || cache_hit) :
                 state == FILL || (state == WRITE && sram_ready);
  assign sram_r_en = state == FETCH0 || state == FETCH1;
  assign sram_w_en = state == WRITE;
  assign sram_addr = state == FETCH0 ? {blk, 3'b000} : state == FETCH1 ? {blk, 3'b100} : cache_addr;
  assign sram_wdata = wdata;
  assign cache_fill_en = state == FILL;
  assign cache_fill_w0 = word0;
  assign cache_fill_w1 = word1;
  // The invalidate is a Mealy pulse in IDLE, so it must be masked while reset is held.
  assign cache_inval = st && cache_hit && !rst;
`ifdef CACHE_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      if (ld_hit && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      if (ld_miss && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: randomized and directed self-checking bench for cache_ctrl against an SRAM-contents model.
module tb_cache_ctrl;
  logic clk = 0, rst = 1;
  logic mem_r_en = 0, mem_w_en = 0;
  logic [31:0] address = 0, wdata = 0, rdata;
  logic ready;
  logic [18:0] cache_addr;
  logic cache_hit = 0;
  logic [31:0] cache_rdata = 0;
  logic cache_fill_en, cache_inval;
  logic [31:0] cache_fill_w0, cache_fill_w1;
  logic [18:0] sram_addr;
  logic [31:0] sram_wdata;
  logic sram_r_en, sram_w_en;
  logic [31:0] sram_rdata = 0;
  logic sram_ready = 0;
`ifdef CACHE_CTRL_PERF_CNT_EN
  logic [15:0] hit_count, miss_count;
`endif
  int checks = 0, errors = 0;
  logic [31:0] sram [bit [18:0]];

  cache_ctrl dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .address(address),
    .wdata(wdata), .rdata(rdata), .ready(ready), .cache_addr(cache_addr), .cache_hit(cache_hit),
    .cache_rdata(cache_rdata), .cache_fill_en(cache_fill_en), .cache_fill_w0(cache_fill_w0),
    .cache_fill_w1(cache_fill_w1), .cache_inval(cache_inval), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready)
`ifdef CACHE_CTRL_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] map_addr(input logic [31:0] a);
    logic [31:0] t;
    t = a - 32'd1024;
    return t[18:0];
  endfunction

  function automatic logic [31:0] sram_rd(input logic [18:0] a);
    return sram.exists(a) ? sram[a] : ({13'd0, a} ^ 32'h5A5A_0000);
  endfunction

  task automatic load_miss(input logic [31:0] a, input int lat);
    logic [18:0] c, b0, b1;
    logic [31:0] w0, w1, exp_rd;
    c = map_addr(a);
    b0 = {c[18:3], 3'b000};
    b1 = {c[18:3], 3'b100};
    w0 = sram_rd(b0);
    w1 = sram_rd(b1);
    exp_rd = a[2] ? w1 : w0;
    @(negedge clk);
    address = a; mem_r_en = 1; mem_w_en = 0; cache_hit = 0; #1;
    checks++;
    if (ready !== 0 || cache_addr !== c) begin
      errors++;
      $display("FAIL miss_issue got ready=%b cache_addr=%h exp ready=0 cache_addr=%h", ready, cache_addr, c);
    end
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < lat; k++) begin
        @(negedge clk);
        sram_ready = k == lat - 1;
        sram_rdata = sram_ready ? (p == 1 ? w1 : w0) : $urandom;
        #1;
        checks++;
        if ({sram_r_en, sram_w_en, ready, cache_fill_en} !== 4'b1000 || sram_addr !== (p == 1 ? b1 : b0)) begin
          errors++;
          $display("FAIL miss_fetch%0d got r/w/rdy/fill=%b addr=%h exp 1000 addr=%h",
                   p, {sram_r_en, sram_w_en, ready, cache_fill_en}, sram_addr, p == 1 ? b1 : b0);
        end
      end
    @(negedge clk);
    sram_ready = 0; #1;
    checks++;
    if ({cache_fill_en, ready, sram_r_en, sram_w_en} !== 4'b1100 || cache_fill_w0 !== w0 ||
        cache_fill_w1 !== w1 || rdata !== exp_rd) begin
      errors++;
      $display("FAIL miss_fill got fill/rdy/r/w=%b w0=%h w1=%h rdata=%h exp 1100 w0=%h w1=%h rdata=%h",
               {cache_fill_en, ready, sram_r_en, sram_w_en}, cache_fill_w0, cache_fill_w1, rdata, w0, w1, exp_rd);
    end
    @(negedge clk);
    mem_r_en = 0; #1;
    checks++;
    if ({cache_fill_en, ready, sram_r_en} !== 3'b010) begin
      errors++;
      $display("FAIL miss_done got fill/rdy/r=%b exp 010", {cache_fill_en, ready, sram_r_en});
    end
  endtask

  task automatic load_hit(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; mem_r_en = 1; mem_w_en = 0; cache_hit = 1; cache_rdata = d; #1;
    checks++;
    if ({ready, sram_r_en, sram_w_en, cache_fill_en, cache_inval} !== 5'b10000 || rdata !== d) begin
      errors++;
      $display("FAIL load_hit got rdy/r/w/fill/inv=%b rdata=%h exp 10000 rdata=%h",
               {ready, sram_r_en, sram_w_en, cache_fill_en, cache_inval}, rdata, d);
    end
    @(negedge clk);
    mem_r_en = 0; cache_hit = 0; #1;
    checks++;
    if ({ready, sram_r_en, sram_w_en} !== 3'b100) begin
      errors++;
      $display("FAIL hit_after got rdy/r/w=%b exp 100", {ready, sram_r_en, sram_w_en});
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic hit, input logic both, input int lat);
    logic [18:0] c;
    int invs;
    c = map_addr(a);
    @(negedge clk);
    address = a; wdata = d; mem_w_en = 1; mem_r_en = both; cache_hit = hit; #1;
    invs = cache_inval;
    checks++;
    if (cache_inval !== hit || {ready, sram_r_en, cache_fill_en} !== 3'b000) begin
      errors++;
      $display("FAIL store_issue got inval=%b rdy/r/fill=%b exp inval=%b 000", cache_inval,
               {ready, sram_r_en, cache_fill_en}, hit);
    end
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      sram_ready = k == lat - 1; #1;
      invs += int'(cache_inval);
      checks++;
      if ({sram_w_en, sram_r_en, cache_fill_en, cache_inval} !== 4'b1000 || ready !== sram_ready ||
          sram_addr !== c || sram_wdata !== d) begin
        errors++;
        $display("FAIL store_write got w/r/fill/inv=%b rdy=%b addr=%h wd=%h exp 1000 rdy=%b addr=%h wd=%h",
                 {sram_w_en, sram_r_en, cache_fill_en, cache_inval}, ready, sram_addr, sram_wdata, sram_ready, c, d);
      end
    end
    sram[c] = d;
    @(negedge clk);
    sram_ready = 0; mem_w_en = 0; mem_r_en = 0; cache_hit = 0; #1;
    checks++;
    if ({ready, sram_w_en, sram_r_en} !== 3'b100 || invs !== int'(hit)) begin
      errors++;
      $display("FAIL store_done got rdy/w/r=%b inval_pulses=%0d exp 100 inval_pulses=%0d",
               {ready, sram_w_en, sram_r_en}, invs, int'(hit));
    end
  endtask

  task automatic test_reset;
    rst = 1; #2;
    checks++;
    if ({ready, sram_r_en, sram_w_en, cache_fill_en, cache_inval} !== 5'b10000 || rdata !== 0 ||
        cache_fill_w0 !== 0 || cache_fill_w1 !== 0) begin
      errors++;
      $display("FAIL reset_hold got rdy/r/w/fill/inv=%b rdata=%h w0=%h w1=%h exp 10000 zeros",
               {ready, sram_r_en, sram_w_en, cache_fill_en, cache_inval}, rdata, cache_fill_w0, cache_fill_w1);
    end
    repeat (2) @(negedge clk);
    rst = 0; #1;
    checks++;
    if ({ready, sram_r_en, sram_w_en, cache_fill_en} !== 4'b1000 || rdata !== 0) begin
      errors++;
      $display("FAIL reset_release got rdy/r/w/fill=%b rdata=%h exp 1000 rdata=0",
               {ready, sram_r_en, sram_w_en, cache_fill_en}, rdata);
    end
    address = 32'h0000_0C00; #1;
    checks++;
    if (cache_addr !== 19'h00800) begin
      errors++;
      $display("FAIL cache_addr got %h exp 00800", cache_addr);
    end
  endtask

  task automatic test_load_miss;
    sram[19'h00008] = 32'hAAAA_0000;
    sram[19'h0000C] = 32'hBBBB_1111;
    load_miss(32'h0000_0408, 2);
    load_miss(32'h0000_040C, 2);
  endtask

  task automatic test_load_hit;
    load_hit(32'h0000_0500, 32'h1234_5678);
  endtask

  task automatic test_store_hit;
    store(32'h0000_0410, 32'hDEAD_BEEF, 1'b1, 1'b0, 2);
    load_miss(32'h0000_0410, 1);
  endtask

  task automatic test_both_enables;
    store(32'h0000_0420, 32'hCAFE_F00D, 1'b0, 1'b1, 3);
    store(32'h0000_0424, 32'h0BAD_CAFE, 1'b1, 1'b1, 1);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    address = 32'h0000_0430; mem_r_en = 1; cache_hit = 0;
    @(negedge clk);
    sram_ready = 1; sram_rdata = 32'h1111_2222;
    @(negedge clk);
    sram_ready = 0; #1;
    checks++;
    if (sram_r_en !== 1 || sram_addr !== 19'h00034) begin
      errors++;
      $display("FAIL rst_mid_pre got r=%b addr=%h exp r=1 addr=00034", sram_r_en, sram_addr);
    end
    #1 rst = 1; #1;
    checks++;
    if ({sram_r_en, sram_w_en, cache_fill_en} !== 3'b000 || cache_fill_w0 !== 0) begin
      errors++;
      $display("FAIL rst_mid_drop got r/w/fill=%b w0=%h exp 000 w0=0", {sram_r_en, sram_w_en, cache_fill_en}, cache_fill_w0);
    end
    @(negedge clk);
    mem_r_en = 0; rst = 0; #1;
    checks++;
    if ({ready, sram_r_en, cache_fill_en} !== 3'b100 || rdata !== 0) begin
      errors++;
      $display("FAIL rst_mid_idle got rdy/r/fill=%b rdata=%h exp 100 rdata=0", {ready, sram_r_en, cache_fill_en}, rdata);
    end
    @(negedge clk); #1;
    checks++;
    if ({ready, sram_r_en, cache_fill_en} !== 3'b100) begin
      errors++;
      $display("FAIL rst_mid_nofill got rdy/r/fill=%b exp 100", {ready, sram_r_en, cache_fill_en});
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      a = 32'd1024 + ($urandom_range(0, 31) << 2);
      case ($urandom_range(0, 3))
        0: load_hit(a, $urandom);
        1: load_miss(a, $urandom_range(1, 3));
        2: store(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 3));
        default: begin
          @(negedge clk);
          sram_ready = 1; #1;
          @(negedge clk);
          sram_ready = 0; #1;
          checks++;
          if ({ready, sram_r_en, sram_w_en, cache_fill_en} !== 4'b1000) begin
            errors++;
            $display("FAIL idle_ignore got rdy/r/w/fill=%b exp 1000", {ready, sram_r_en, sram_w_en, cache_fill_en});
          end
        end
      endcase
    end
  endtask

`ifdef CACHE_CTRL_PERF_CNT_EN
  task automatic test_perf_cnt;
    @(negedge clk);
    rst = 1; #1;
    checks++;
    if (hit_count !== 0 || miss_count !== 0) begin
      errors++;
      $display("FAIL perf_reset got hit=%0d miss=%0d exp 0 0", hit_count, miss_count);
    end
    @(negedge clk);
    rst = 0;
    load_hit(32'h0000_0600, 32'h1);
    load_miss(32'h0000_0608, 1);
    load_hit(32'h0000_0604, 32'h2);
    load_miss(32'h0000_0610, 2);
    load_hit(32'h0000_0614, 32'h3);
    checks++;
    if (hit_count !== 16'd3 || miss_count !== 16'd2) begin
      errors++;
      $display("FAIL perf_count got hit=%0d miss=%0d exp 3 2", hit_count, miss_count);
    end
    @(negedge clk);
    force dut.hit_count = 16'hFFFF;
    #1 release dut.hit_count;
    load_hit(32'h0000_0618, 32'h4);
    checks++;
    if (hit_count !== 16'hFFFF || miss_count !== 16'd2) begin
      errors++;
      $display("FAIL perf_saturate got hit=%h miss=%0d exp ffff 2", hit_count, miss_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_miss();
    test_load_hit();
    test_store_hit();
    test_both_enables();
    test_reset_mid();
    test_random();
`ifdef CACHE_CTRL_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
